// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle RV32I control FSM (fetch/decode/execute/mem/wb)
// with memory wait states (ready/valid or fixed MEM_LATENCY). `MC_SHIFT_EN adds shifts.
// In : clk, reset, opcode, funct3, funct7_b5, alu_zero/lt/ltu, mem_ready
// Out: pc_write, adr_source, mem_read, mem_write, ir_write, reg_write,
//      imm_source, alu_src_a, alu_src_b, alu_control, result_source,
//      instr_done, illegal_instr
module mc_control_fsm #(
  parameter int ALU_CTRL_W    = 4,
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int MEM_LATENCY   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic                  funct7_b5,
  input  logic                  alu_zero,
  input  logic                  alu_lt,
  input  logic                  alu_ltu,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  adr_source,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic                  reg_write,
  output logic [2:0]            imm_source,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [1:0]            result_source,
  output logic                  instr_done,
  output logic                  illegal_instr
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXECUTE,
    S_MEM_RD, S_WB_MEM, S_MEM_WR, S_WB_ALU,
    S_WB_LINK, S_JUMP, S_BR_TAKEN, S_PC_PLUS_4
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic          mem_done;
  logic [3:0]    alu_op;
  logic          alu_ok;
  logic          br_taken;
  logic          br_ok;
  logic [3:0]    alu_sel;

  assign mem_done = MEM_HANDSHAKE ? mem_ready
                                  : (cnt == CW'(MEM_LATENCY - 1));

  assign alu_control = ALU_CTRL_W'(alu_sel);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RESET;
    end else begin
      state <= state_n;
    end
  end

  // Wait counter restarts whenever the state changes.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (state_n != state) begin
      cnt <= '0;
    end else if (!mem_done) begin
      cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    alu_op = 4'd0;
    alu_ok = 1'b1;
    case (funct3)
      3'b000:  alu_op = (opcode == OP_R && funct7_b5) ? 4'd1 : 4'd0;
      3'b100:  alu_op = 4'd4;
      3'b110:  alu_op = 4'd3;
      3'b111:  alu_op = 4'd2;
      3'b010:  alu_op = 4'd5;
      3'b011:  alu_op = 4'd6;
`ifdef MC_SHIFT_EN
      3'b001:  alu_op = 4'd7;
      3'b101:  alu_op = funct7_b5 ? 4'd9 : 4'd8;
`else
      3'b001:  alu_ok = 1'b0;
      3'b101:  alu_ok = 1'b0;
`endif
      default: alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    br_ok    = 1'b1;
    case (funct3)
      3'b000:  br_taken = alu_zero;
      3'b001:  br_taken = !alu_zero;
      3'b100:  br_taken = alu_lt;
      3'b101:  br_taken = !alu_lt;
      3'b110:  br_taken = alu_ltu;
      3'b111:  br_taken = !alu_ltu;
      default: br_ok    = 1'b0;
    endcase
  end

  always_comb begin
    state_n       = S_FETCH;
    pc_write      = 1'b0;
    adr_source    = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    imm_source    = 3'd0;
    alu_src_a     = 2'd0;
    alu_src_b     = 2'd0;
    alu_sel       = 4'd0;
    result_source = 2'd0;
    instr_done    = 1'b0;
    illegal_instr = 1'b0;

    case (state)
      S_RESET: state_n = S_FETCH;

      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_done) begin
          ir_write = 1'b1;
          state_n  = S_DECODE;
        end else begin
          state_n  = S_FETCH;
        end
      end

      S_DECODE: begin
        state_n = S_EXECUTE;
        case (opcode)
          OP_STORE:        imm_source = 3'd1;
          OP_BR:           imm_source = 3'd2;
          OP_JAL:          imm_source = 3'd3;
          OP_LUI, OP_AUIPC: imm_source = 3'd4;
          default:         imm_source = 3'd0;
        endcase
      end

      S_EXECUTE: begin
        state_n = S_PC_PLUS_4;
        case (opcode)
          OP_LOAD: begin
            alu_src_a = 2'd2;
            alu_src_b = 2'd1;
            state_n   = S_MEM_RD;
          end
          OP_STORE: begin
            alu_src_a  = 2'd2;
            alu_src_b  = 2'd1;
            imm_source = 3'd1;
            state_n    = S_MEM_WR;
          end
          OP_R, OP_I: begin
            if (alu_ok) begin
              alu_src_a = 2'd2;
              alu_src_b = (opcode == OP_I) ? 2'd1 : 2'd0;
              alu_sel   = alu_op;
              state_n   = S_WB_ALU;
            end else begin
              illegal_instr = 1'b1;
            end
          end
          OP_LUI: begin
            alu_src_a  = 2'd3;
            alu_src_b  = 2'd1;
            imm_source = 3'd4;
            state_n    = S_WB_ALU;
          end
          OP_AUIPC: begin
            alu_src_a  = 2'd1;
            alu_src_b  = 2'd1;
            imm_source = 3'd4;
            state_n    = S_WB_ALU;
          end
          OP_JAL, OP_JALR: begin
            alu_src_a = 2'd1;
            alu_src_b = 2'd2;
            state_n   = S_WB_LINK;
          end
          OP_BR: begin
            if (br_ok) begin
              alu_src_a = 2'd2;
              alu_src_b = 2'd0;
              alu_sel   = 4'd1;
              state_n   = br_taken ? S_BR_TAKEN : S_PC_PLUS_4;
            end else begin
              illegal_instr = 1'b1;
            end
          end
          default: illegal_instr = 1'b1;
        endcase
      end

      S_MEM_RD: begin
        mem_read   = 1'b1;
        adr_source = 1'b1;
        state_n    = mem_done ? S_WB_MEM : S_MEM_RD;
      end

      S_WB_MEM: begin
        result_source = 2'd1;
        reg_write     = 1'b1;
        state_n       = S_PC_PLUS_4;
      end

      S_MEM_WR: begin
        mem_write  = 1'b1;
        adr_source = 1'b1;
        state_n    = mem_done ? S_PC_PLUS_4 : S_MEM_WR;
      end

      S_WB_ALU, S_WB_LINK: begin
        result_source = 2'd2;
        reg_write     = 1'b1;
        state_n       = (state == S_WB_LINK) ? S_JUMP : S_PC_PLUS_4;
      end

      S_JUMP: begin
        // JALR target bit 0 is cleared in the datapath.
        if (opcode == OP_JALR) begin
          alu_src_a  = 2'd2;
          imm_source = 3'd0;
        end else begin
          alu_src_a  = 2'd1;
          imm_source = 3'd3;
        end
        alu_src_b  = 2'd1;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end

      S_BR_TAKEN: begin
        alu_src_a  = 2'd1;
        alu_src_b  = 2'd1;
        imm_source = 3'd2;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end

      S_PC_PLUS_4: begin
        alu_src_a  = 2'd1;
        alu_src_b  = 2'd2;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end

      default: state_n = S_FETCH;
    endcase

    // Reset kills any in-flight request in the same cycle.
    if (reset) begin
      pc_write      = 1'b0;
      adr_source    = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      imm_source    = 3'd0;
      alu_src_a     = 2'd0;
      alu_src_b     = 2'd0;
      alu_sel       = 4'd0;
      result_source = 2'd0;
      instr_done    = 1'b0;
      illegal_instr = 1'b0;
    end
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Parametrised multicycle RISC-V control FSM, the successor to the current single-latency control unit. It sequences fetch, decode, execute, memory and writeback for RV32I base integer instructions: loads/stores, R/I ALU ops, the full branch set including unsigned, JAL, JALR, LUI and AUIPC. It adds memory wait-state support in two modes, a ready/valid handshake or a fixed latency. It sits between the instruction register/ALU flags and the shared-memory multicycle datapath.

Parameters:
ALU_CTRL_W, 4, alu_control width; must be >=4, upper bits zero.
MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = fixed latency.
MEM_LATENCY, 1, cycles spent per memory state when MEM_HANDSHAKE=0; must be >=1.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
opcode  in  7  instr[6:0]
funct3  in  3  instr[14:12]
funct7_b5  in  1  instr[30]
alu_zero  in  1  ALU result == 0
alu_lt  in  1  signed rs1<rs2
alu_ltu  in  1  unsigned rs1<rs2
mem_ready  in  1  memory access complete; ignored when MEM_HANDSHAKE=0
pc_write  out  1  load PC from result bus
adr_source  out  1  0=PC, 1=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  latch instruction and OldPC
reg_write  out  1  register file write
imm_source  out  3  0=I 1=S 2=B 3=J 4=U
alu_src_a  out  2  0=PC 1=OldPC 2=RD1 3=zero
alu_src_b  out  2  0=RD2 1=ImmExt 2=const 4
alu_control  out  ALU_CTRL_W  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA
result_source  out  2  0=ALUResult 1=MemData 2=ALUOut
instr_done  out  1  one-cycle pulse on the PC-update cycle
illegal_instr  out  1  one-cycle pulse on an unsupported encoding

Behaviour:
- Reset:
  - While reset=1, all outputs are forced to 0 combinationally.
  - The next edge puts the FSM in RESET; RESET always goes to FETCH.
  - A reset mid-access drops mem_write/mem_read in that same cycle.
- Defaults: every output not listed for a state is 0.
- Memory wait:
  - Handshake mode: FETCH, MEM_RD and MEM_WR hold until mem_ready=1.
  - Fixed mode: a counter holds each of those states exactly MEM_LATENCY cycles.
  - The counter clears on state entry.
- FETCH: mem_read=1, adr_source=0. On the completing cycle, ir_write=1 -> DECODE.
- DECODE: imm_source chosen from opcode -> EXECUTE.
- EXECUTE, by opcode:
  - Load/store: src_a=RD1, src_b=Imm (I/S), ADD -> MEM_RD / MEM_WR.
  - R-type: src_a=RD1, src_b=RD2.
  - I-type ALU: src_a=RD1, src_b=Imm.
  - R/I ALU op select: funct3 000 ADD; SUB only when R-type and funct7_b5=1. 100 XOR, 110 OR, 111 AND, 010 SLT, 011 SLTU. -> WB_ALU.
  - LUI: src_a=zero, src_b=Imm(U), ADD -> WB_ALU.
  - AUIPC: src_a=OldPC, src_b=Imm(U), ADD -> WB_ALU.
  - JAL/JALR: src_a=OldPC, src_b=4, ADD -> WB_LINK.
  - Branch: src_a=RD1, src_b=RD2, SUB. Taken condition by funct3: BEQ alu_zero, BNE !alu_zero, BLT alu_lt, BGE !alu_lt, BLTU alu_ltu, BGEU !alu_ltu. Taken -> BR_TAKEN, else PC_PLUS_4.
  - Branch funct3 010/011: illegal.
- MEM_RD: mem_read=1, adr_source=1 -> WB_MEM.
- WB_MEM: result_source=1, reg_write=1 -> PC_PLUS_4.
- MEM_WR: mem_write=1, adr_source=1 -> PC_PLUS_4.
- WB_ALU: result_source=2, reg_write=1 -> PC_PLUS_4.
- WB_LINK: result_source=2, reg_write=1 -> JUMP.
- JUMP:
  - JAL: src_a=OldPC, src_b=Imm(J).
  - JALR: src_a=RD1, src_b=Imm(I); the datapath clears bit 0.
  - Both: ADD, result_source=0, pc_write=1 -> FETCH.
- BR_TAKEN: src_a=OldPC, src_b=Imm(B), ADD, result_source=0, pc_write=1 -> FETCH.
- PC_PLUS_4: src_a=OldPC, src_b=4, ADD, result_source=0, pc_write=1 -> FETCH.
- instr_done=1 in JUMP, BR_TAKEN and PC_PLUS_4.
- Illegal opcode or funct3: illegal_instr=1 in EXECUTE -> PC_PLUS_4 (executes as NOP, no register or memory write).
- Unreachable state encodings -> FETCH with all outputs 0.
- Cycle counts with 1-cycle memory: ALU op 5, load 6, store 5, branch 4, JAL 5.

Optional Feature:
MC_SHIFT_EN:
- Defined: SLL/SLLI (funct3 001), SRL/SRLI and SRA/SRAI (funct3 101) are decoded; SRA/SRAI when funct7_b5=1. Shift ops -> WB_ALU.
- Undefined: those encodings are illegal, pulse illegal_instr, and take the NOP path.

Test Plan:
- reset=1 for 2 cycles during MEM_WR -> mem_write=0 in the reset cycle; after release, RESET then FETCH with mem_read=1.
- add (funct7_b5=0, funct3=000), 1-cycle memory -> alu_control=0 in EXECUTE; reg_write=1 in WB_ALU; instr_done on cycle 5.
- MEM_HANDSHAKE=1, lw, mem_ready low 3 cycles in MEM_RD -> mem_read held 4 cycles, then WB_MEM with result_source=1, reg_write=1.
- BLTU with alu_ltu=1, alu_lt=0 -> BR_TAKEN, imm_source=2, pc_write=1. BGE with alu_lt=1 -> PC_PLUS_4.
- JALR -> WB_LINK (reg_write=1, result_source=2), then JUMP (alu_src_a=2, imm_source=0, pc_write=1).
- opcode 7'b1110011 -> illegal_instr pulse, no reg_write, PC_PLUS_4. With MC_SHIFT_EN undefined, SRAI also pulses illegal_instr.
